// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Routes single outstanding core requests to one of three address regions
//   (IROM, DRAM, MMIO) over a valid/ready handshake, returning one response
//   pulse per accepted request.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (accepted only in IDLE)
//   req_we_i, req_addr_i     write flag, byte address
//   req_wdata_i, req_be_i    write data, byte-lane enables
//   resp_valid_o             one-cycle response pulse
//   resp_rdata_o, resp_err_o read data (0 for writes/errors), access error
//   irom_addr_o/irom_rdata_i IROM word index, data one cycle later
//   dram_*                   DRAM word index, write strobe/lanes/data, read data
//   io_*                     MMIO handshaked port, byte offset from IO_BASE
module mem_bus_ctrl #(
   parameter int unsigned             WIDTH      = 32,
   parameter int unsigned             ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]   IROM_BASE  = 'h0,
   parameter logic [ADDR_WIDTH-1:0]   IROM_SIZE  = 'd4096,
   parameter logic [ADDR_WIDTH-1:0]   DRAM_BASE  = 'd4096,
   parameter logic [ADDR_WIDTH-1:0]   DRAM_SIZE  = 'd4096,
   parameter logic [ADDR_WIDTH-1:0]   IO_BASE    = 'h1000_0000,
   parameter logic [ADDR_WIDTH-1:0]   IO_SIZE    = 'd256,
   parameter int unsigned             IO_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [WIDTH-1:0]        req_wdata_i,
   input  logic [WIDTH/8-1:0]      req_be_i,
   output logic                    resp_valid_o,
   output logic [WIDTH-1:0]        resp_rdata_o,
   output logic                    resp_err_o,
   output logic [ADDR_WIDTH-1:0]   irom_addr_o,
   input  logic [WIDTH-1:0]        irom_rdata_i,
   output logic                    dram_we_o,
   output logic [WIDTH/8-1:0]      dram_be_o,
   output logic [ADDR_WIDTH-1:0]   dram_addr_o,
   output logic [WIDTH-1:0]        dram_wdata_o,
   input  logic [WIDTH-1:0]        dram_rdata_i,
   output logic                    io_valid_o,
   output logic                    io_we_o,
   output logic [ADDR_WIDTH-1:0]   io_addr_o,
   output logic [WIDTH-1:0]        io_wdata_o,
   output logic [WIDTH/8-1:0]      io_be_o,
   input  logic                    io_ready_i,
   input  logic [WIDTH-1:0]        io_rdata_i
);

   localparam int unsigned NB      = WIDTH / 8;
   localparam int unsigned LSB     = $clog2(NB);
   localparam logic [7:0]  TO_LAST = 8'(IO_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_IO_WAIT, S_RESP} state_e;
   typedef enum logic [1:0] {R_NONE, R_IROM, R_DRAM, R_IO} region_e;

   state_e                  state_q, state_d;
   region_e                 region_q;
   logic                    we_q, err_q;
   logic [ADDR_WIDTH-1:0]   io_addr_q;
   logic [WIDTH-1:0]        io_wdata_q, rdata_q;
   logic [NB-1:0]           io_be_q;
   logic [7:0]              wait_cnt;

   logic [ADDR_WIDTH-1:0]   irom_off, dram_off, io_off;
   logic                    irom_hit, dram_hit, io_hit, misaligned, req_err, accept;

   // Offsets are taken at ADDR_WIDTH so the size compare cannot overflow.
   assign irom_off   = req_addr_i - IROM_BASE;
   assign dram_off   = req_addr_i - DRAM_BASE;
   assign io_off     = req_addr_i - IO_BASE;
   assign irom_hit   = (req_addr_i >= IROM_BASE) && (irom_off < IROM_SIZE);
   assign dram_hit   = !irom_hit && (req_addr_i >= DRAM_BASE) && (dram_off < DRAM_SIZE);
   assign io_hit     = !irom_hit && !dram_hit && (req_addr_i >= IO_BASE) && (io_off < IO_SIZE);
   assign misaligned = (req_addr_i & ADDR_WIDTH'(NB - 1)) != '0;
   assign req_err    = misaligned || !(irom_hit || dram_hit || io_hit) || (irom_hit && req_we_i);
   assign accept     = req_valid_i && (state_q == S_IDLE);

   assign irom_addr_o  = irom_off >> LSB;
   assign dram_addr_o  = dram_off >> LSB;
   assign dram_we_o    = accept && dram_hit && req_we_i && !req_err;
   assign dram_be_o    = req_be_i;
   assign dram_wdata_o = req_wdata_i;

   assign io_valid_o = (state_q == S_IO_WAIT);
   assign io_we_o    = we_q;
   assign io_addr_o  = io_addr_q;
   assign io_wdata_o = io_wdata_q;
   assign io_be_o    = io_be_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         region_q   <= R_NONE;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         io_addr_q  <= '0;
         io_wdata_q <= '0;
         io_be_q    <= '0;
         rdata_q    <= '0;
         wait_cnt   <= '0;
      end else if (accept) begin
         we_q       <= req_we_i;
         err_q      <= req_err;
         region_q   <= req_err  ? R_NONE :
                       irom_hit ? R_IROM :
                       dram_hit ? R_DRAM : R_IO;
         io_addr_q  <= io_off;
         io_wdata_q <= req_wdata_i;
         io_be_q    <= req_be_i;
         rdata_q    <= '0;
         wait_cnt   <= '0;
      end else if (state_q == S_IO_WAIT) begin
         // Ready on the final wait cycle still wins over the timeout.
         if (io_ready_i) begin
            rdata_q <= we_q ? '0 : io_rdata_i;
            err_q   <= 1'b0;
         end else if (wait_cnt == TO_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end else begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_err_o   = 1'b0;
      resp_rdata_o = '0;
      case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = (io_hit && !req_err) ? S_IO_WAIT : S_MEM;
         end
         S_MEM: begin
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
            if (!err_q && !we_q) begin
               if (region_q == R_IROM)      resp_rdata_o = irom_rdata_i;
               else if (region_q == R_DRAM) resp_rdata_o = dram_rdata_i;
            end
            state_d = S_IDLE;
         end
         S_IO_WAIT: begin
            if (io_ready_i || wait_cnt == TO_LAST) state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
            resp_rdata_o = rdata_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl
//   Drives mem_bus_ctrl with directed and random requests. Expected responses
//   come from a transaction-level model of the address map, a shadow DRAM
//   array and the peripheral's configured ready delay.
module tb_mem_bus_ctrl;

   localparam logic [31:0] IO_BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0, req_we_i = 1'b0;
   logic [31:0] req_addr_i = '0, req_wdata_i = '0;
   logic [3:0]  req_be_i = '0;
   logic        req_ready_o, resp_valid_o, resp_err_o;
   logic [31:0] resp_rdata_o, irom_addr_o, irom_rdata_i;
   logic        dram_we_o;
   logic [3:0]  dram_be_o;
   logic [31:0] dram_addr_o, dram_wdata_o, dram_rdata_i;
   logic        io_valid_o, io_we_o;
   logic [31:0] io_addr_o, io_wdata_o;
   logic [3:0]  io_be_o;
   logic        io_ready_i = 1'b0;
   logic [31:0] io_rdata_i = '0;

   mem_bus_ctrl #(
      .WIDTH(32), .ADDR_WIDTH(32),
      .IROM_BASE(32'd0), .IROM_SIZE(32'd4096),
      .DRAM_BASE(32'd4096), .DRAM_SIZE(32'd4096),
      .IO_BASE(IO_BASE), .IO_SIZE(32'd256), .IO_TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .irom_addr_o(irom_addr_o), .irom_rdata_i(irom_rdata_i),
      .dram_we_o(dram_we_o), .dram_be_o(dram_be_o), .dram_addr_o(dram_addr_o),
      .dram_wdata_o(dram_wdata_o), .dram_rdata_i(dram_rdata_i),
      .io_valid_o(io_valid_o), .io_we_o(io_we_o), .io_addr_o(io_addr_o),
      .io_wdata_o(io_wdata_o), .io_be_o(io_be_o), .io_ready_i(io_ready_i),
      .io_rdata_i(io_rdata_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] irom_fn(input logic [31:0] idx);
      return (idx * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] dinit(input int i);
      return 32'hC0DE_0000 + 32'(i * 7);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = wd[8*l +: 8];
      return r;
   endfunction

   // Memory side of the bus: IROM contents are a fixed function of word index.
   logic [31:0] dram_mem [0:1023];
   logic [31:0] ref_dram [0:1023];

   always @(posedge clk) irom_rdata_i <= irom_fn(irom_addr_o);

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) dram_mem[i] <= dinit(i);
      end else if (dram_we_o === 1'b1 && dram_addr_o < 32'd1024) begin
         dram_mem[dram_addr_o[9:0]] <= merge(dram_mem[dram_addr_o[9:0]], dram_wdata_o, dram_be_o);
      end
      dram_rdata_i <= (dram_addr_o < 32'd1024) ? dram_mem[dram_addr_o[9:0]] : 32'hBAD0_BAD0;
   end

   // Peripheral: raises ready on the io_delay-th cycle of io_valid_o.
   int          io_cnt = 0;
   int          io_delay = 1000;
   logic [31:0] io_resp_data = '0;

   always @(negedge clk) begin
      if (io_valid_o === 1'b1) begin
         io_cnt++;
         if (io_cnt == io_delay) begin
            io_ready_i = 1'b1;
            io_rdata_i = io_resp_data;
         end else begin
            io_ready_i = 1'b0;
            io_rdata_i = $urandom;
         end
      end else begin
         io_cnt     = 0;
         io_ready_i = 1'b0;
         io_rdata_i = $urandom;
      end
   end

   // Expected behaviour of the single outstanding transaction.
   int          cyc = 0;
   bit          mon_en = 0;
   bit          pending = 0;
   int          acc_cyc, resp_cyc, io_first, io_last;
   bit          exp_err, exp_io, exp_dram_we, exp_io_we;
   logic [31:0] exp_rdata, exp_dram_addr, exp_dram_wdata, exp_io_addr, exp_io_wdata;
   logic [3:0]  exp_dram_be, exp_io_be;
   int          n_acc = 0, n_resp = 0, n_abort = 0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;
   int          io_run = 0, last_io_run = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      bit busy, io_exp, at_acc, at_resp;
      #2;
      if (mon_en && !rst) begin
         busy    = pending && cyc > acc_cyc && cyc <= resp_cyc;
         at_acc  = pending && cyc == acc_cyc;
         at_resp = pending && cyc == resp_cyc;
         io_exp  = pending && exp_io && cyc >= io_first && cyc <= io_last;
         chk("req_ready", {31'd0, req_ready_o}, {31'd0, !busy});
         chk("resp_valid", {31'd0, resp_valid_o}, {31'd0, at_resp});
         chk("io_valid", {31'd0, io_valid_o}, {31'd0, io_exp});
         chk("dram_we", {31'd0, dram_we_o}, {31'd0, at_acc && exp_dram_we});
         if (io_exp) begin
            chk("io_addr", io_addr_o, exp_io_addr);
            chk("io_we", {31'd0, io_we_o}, {31'd0, exp_io_we});
            if (exp_io_we) begin
               chk("io_wdata", io_wdata_o, exp_io_wdata);
               chk("io_be", {28'd0, io_be_o}, {28'd0, exp_io_be});
            end
         end
         if (at_acc && exp_dram_we) begin
            chk("dram_addr", dram_addr_o, exp_dram_addr);
            chk("dram_wdata", dram_wdata_o, exp_dram_wdata);
            chk("dram_be", {28'd0, dram_be_o}, {28'd0, exp_dram_be});
         end
         if (io_valid_o === 1'b1) io_run++;
         else if (io_run != 0) begin
            last_io_run = io_run;
            io_run      = 0;
         end
         if (resp_valid_o === 1'b1) begin
            n_resp++;
            last_rdata = resp_rdata_o;
            last_err   = resp_err_o;
            if (at_resp) begin
               chk("resp_rdata", resp_rdata_o, exp_rdata);
               chk("resp_err", {31'd0, resp_err_o}, {31'd0, exp_err});
            end
         end
         if (at_resp) pending = 0;
      end
   end

   // Presents a request and returns just after it is accepted, leaving
   // req_valid_i high so the caller may chain another request.
   task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int d, input logic [31:0] iod);
      int     n;
      bit     got;
      longint a;
      int     idx, dd;
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_be_i    = be;
      n = 0;
      got = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         if (req_ready_o === 1'b1) got = 1;
         else n++;
      end
      chk("accept_wait", {31'd0, got}, 32'd1);
      if (!got) begin
         req_valid_i = 1'b0;
         return;
      end
      a = longint'(addr);
      acc_cyc     = cyc;
      resp_cyc    = cyc + 1;
      exp_err     = 0;
      exp_io      = 0;
      exp_dram_we = 0;
      exp_rdata   = '0;
      if (a % 4 != 0) exp_err = 1;
      else if (a < 4096) begin
         if (we) exp_err = 1;
         else    exp_rdata = irom_fn(32'(a / 4));
      end else if (a < 8192) begin
         idx = int'((a - 4096) / 4);
         if (we) begin
            exp_dram_we    = 1;
            exp_dram_addr  = 32'(idx);
            exp_dram_wdata = wdata;
            exp_dram_be    = be;
            ref_dram[idx]  = merge(ref_dram[idx], wdata, be);
         end else exp_rdata = ref_dram[idx];
      end else if (a >= longint'(IO_BASE) && a < longint'(IO_BASE) + 256) begin
         dd           = (d > 16) ? 16 : d;
         exp_io       = 1;
         exp_io_we    = we;
         exp_io_addr  = 32'(a - longint'(IO_BASE));
         exp_io_wdata = wdata;
         exp_io_be    = be;
         io_first     = cyc + 1;
         io_last      = cyc + dd;
         resp_cyc     = io_last + 1;
         exp_err      = (d > 16);
         exp_rdata    = (!we && d <= 16) ? iod : 32'd0;
         io_delay     = d;
         io_resp_data = iod;
      end else exp_err = 1;
      pending = 1;
      n_acc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      int n;
      req_valid_i = 1'b0;
      n = 0;
      while (pending && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("resp_wait", {31'd0, pending}, 32'd0);
      pending = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] addr);
      issue(1'b0, addr, 32'd0, 4'hF, 1, 32'd0);
      idle();
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      issue(1'b1, addr, wd, be, 1, 32'd0);
      idle();
   endtask

   task automatic check_idle_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
      chk({tag, "_resp_valid"}, {31'd0, resp_valid_o}, 32'd0);
      chk({tag, "_resp_err"}, {31'd0, resp_err_o}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata_o, 32'd0);
      chk({tag, "_io_valid"}, {31'd0, io_valid_o}, 32'd0);
      chk({tag, "_dram_we"}, {31'd0, dram_we_o}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] addr;
      for (int i = 0; i < 1024; i++) ref_dram[i] = dinit(i);
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1;
      check_idle_outputs("reset");

      // Full-word write then read back.
      wr(32'd4096, 32'hDEAD_BEEF, 4'hF);
      rd(32'd4096);
      chk("lit_dram_rd", last_rdata, 32'hDEAD_BEEF);
      chk("lit_dram_err", {31'd0, last_err}, 32'd0);

      // Single-lane write merges into the previous word.
      wr(32'd4100, 32'h1122_3344, 4'hF);
      wr(32'd4100, 32'h0000_00AA, 4'b0001);
      rd(32'd4100);
      chk("lit_byte_lane", last_rdata, 32'h1122_33AA);

      // Error cases.
      wr(32'd0, 32'h1234_5678, 4'hF);
      chk("lit_irom_wr_err", {31'd0, last_err}, 32'd1);
      chk("lit_irom_wr_data", last_rdata, 32'd0);
      rd(32'd8192);
      chk("lit_unmapped_err", {31'd0, last_err}, 32'd1);
      rd(32'd4097);
      chk("lit_misalign_err", {31'd0, last_err}, 32'd1);
      chk("lit_misalign_data", last_rdata, 32'd0);
      rd(32'd8);
      chk("lit_irom_rd", last_rdata, irom_fn(32'd2));

      // MMIO handshake, timeout, and ready on the last allowed cycle.
      issue(1'b0, IO_BASE + 32'd8, 32'd0, 4'hF, 3, 32'h55);
      idle();
      chk("lit_io_rdata", last_rdata, 32'h55);
      chk("lit_io_run3", last_io_run, 32'd3);
      issue(1'b0, IO_BASE + 32'd12, 32'd0, 4'hF, 1000, 32'h77);
      idle();
      chk("lit_io_to_err", {31'd0, last_err}, 32'd1);
      chk("lit_io_to_run", last_io_run, 32'd16);
      issue(1'b0, IO_BASE + 32'd12, 32'd0, 4'hF, 16, 32'h99);
      idle();
      chk("lit_io_last_err", {31'd0, last_err}, 32'd0);
      chk("lit_io_last_data", last_rdata, 32'h99);
      chk("lit_io_last_run", last_io_run, 32'd16);

      // Reset while waiting on the peripheral aborts without a response.
      issue(1'b0, IO_BASE + 32'd4, 32'd0, 4'hF, 1000, 32'h66);
      req_valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      pending = 0;
      n_abort++;
      io_run  = 0;
      for (int i = 0; i < 1024; i++) ref_dram[i] = dinit(i);
      check_idle_outputs("abort");

      // Back-to-back with req_valid_i held high throughout.
      issue(1'b1, 32'd4200, 32'hCAFE_F00D, 4'hF, 1, 32'd0);
      issue(1'b0, 32'd4200, 32'd0, 4'hF, 1, 32'd0);
      issue(1'b0, IO_BASE + 32'd16, 32'd0, 4'hF, 2, 32'hABCD_0123);
      issue(1'b1, IO_BASE + 32'd20, 32'h0F0F_0F0F, 4'b1010, 5, 32'h1);
      issue(1'b0, 32'd64, 32'd0, 4'hF, 1, 32'd0);
      issue(1'b0, 32'd9000, 32'd0, 4'hF, 1, 32'd0);
      issue(1'b1, 32'd4200, 32'h1111_2222, 4'h0, 1, 32'd0);
      issue(1'b0, 32'd4200, 32'd0, 4'hF, 1, 32'd0);
      idle();
      chk("lit_be0_keep", last_rdata, 32'hCAFE_F00D);

      // Random traffic across all regions and error classes.
      for (int t = 0; t < 300; t++) begin
         case ($urandom_range(0, 5))
            0:       addr = 32'(4 * $urandom_range(0, 1023));
            1, 2:    addr = 32'd4096 + 32'(4 * $urandom_range(0, 15));
            3:       addr = IO_BASE + 32'(4 * $urandom_range(0, 63));
            4: begin
               case ($urandom_range(0, 3))
                  0:       addr = 32'd8192;
                  1:       addr = 32'h0FFF_FFFC;
                  2:       addr = IO_BASE + 32'd256;
                  default: addr = 32'hFFFF_FFFC;
               endcase
            end
            default: addr = (($urandom_range(0, 1) == 0) ? 32'd4096 : IO_BASE)
                            + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
         endcase
         issue(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(1, 20), $urandom);
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();

      chk("resp_count", n_resp, n_acc - n_abort);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
